// File: rtl/det_cnt_scheduler_pkg.sv
// Shared types for the detect/count datapath scheduler: FSM state encoding and index helpers.
// No logic of its own; imported by the picker and the top level.
package det_cnt_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_RUN      = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERR      = 3'd5
  } sched_state_t;

  // Modular add for requester indices; both operands are already below n.
  function automatic int wrap_add(input int a, input int b, input int n);
    return ((a + b) >= n) ? (a + b - n) : (a + b);
  endfunction

endpackage

// File: rtl/det_cnt_scheduler_rr_pick.sv
// Rotate-priority picker: first set request at or after i_ptr, wrapping. Purely combinational,
// zero latency, no backpressure; o_vld low when nothing is requested.
module det_cnt_scheduler_rr_pick
  import det_cnt_scheduler_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [IW-1:0]   o_idx,
  output logic            o_vld
);

  logic [NREQ-1:0] w_rot;
  logic [IW-1:0]   w_off;

  // Rotate so that bit 0 is the requester at ptr; the lowest set bit is then the winner.
  assign w_rot = NREQ'({i_req, i_req} >> i_ptr);

  always_comb begin
    w_off = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (w_rot[j]) w_off = IW'(j);
    end
  end

  assign o_vld = |w_rot;
  assign o_idx = IW'(wrap_add(int'(i_ptr), int'(w_off), NREQ));

endmodule

// File: rtl/det_cnt_scheduler.sv
// Round-robin owner of one detect/count datapath: grant, start pulse, track ready, done/err.
// gnt+dp_start 1 cycle after arbitration; done 1 cycle after ready returns; all outputs registered.
module det_cnt_scheduler
  import det_cnt_scheduler_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TO_W    = 10,
  parameter int TIMEOUT = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic [NREQ-1:0]         err,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy,
  output logic                    dp_start,
  input  logic                    dp_ready,
  output logic                    dp_abort
);

  localparam int              IW      = $clog2(NREQ);
  localparam logic            TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : (TIMEOUT - 1));

  sched_state_t    r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_owner;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic [NREQ-1:0] r_err;
  logic            r_busy;
  logic            r_start;
  logic            r_abort;
  logic [TO_W-1:0] r_tcnt;

  logic [IW-1:0]   w_pick_idx;
  logic            w_pick_vld;
  logic [NREQ-1:0] w_pick_oh;
  logic [NREQ-1:0] w_owner_oh;
  logic [IW-1:0]   w_next_ptr;
  logic            w_to_hit;
  logic [TO_W-1:0] w_tcnt_inc;

  det_cnt_scheduler_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_idx (w_pick_idx),
    .o_vld (w_pick_vld)
  );

  assign w_pick_oh  = {{(NREQ-1){1'b0}}, 1'b1} << w_pick_idx;
  assign w_owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;
  assign w_next_ptr = IW'(wrap_add(int'(r_owner), 1, NREQ));
  assign w_to_hit   = TO_EN && (r_tcnt == TO_LAST);
  // Saturating so a disabled timeout can never wrap back into a stale match.
  assign w_tcnt_inc = (r_tcnt == {TO_W{1'b1}}) ? r_tcnt : (r_tcnt + 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_err   <= '0;
      r_busy  <= 1'b0;
      r_start <= 1'b0;
      r_abort <= 1'b0;
      r_tcnt  <= '0;
    end else begin
      r_start <= 1'b0;
      r_done  <= '0;
      r_err   <= '0;
      r_abort <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_vld && dp_ready) begin
            r_owner <= w_pick_idx;
            r_gnt   <= w_pick_oh;
            r_busy  <= 1'b1;
            r_start <= 1'b1;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          r_tcnt  <= '0;
          r_state <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (!dp_ready) begin
            r_tcnt  <= '0;
            r_state <= ST_RUN;
          end else if (w_to_hit) begin
            r_err   <= w_owner_oh;
            r_abort <= 1'b1;
            r_state <= ST_ERR;
          end else begin
            r_tcnt  <= w_tcnt_inc;
          end
        end
        ST_RUN: begin
          if (dp_ready) begin
            r_done  <= w_owner_oh;
            r_state <= ST_DONE;
          end else if (w_to_hit) begin
            r_err   <= w_owner_oh;
            r_abort <= 1'b1;
            r_state <= ST_ERR;
          end else begin
            r_tcnt  <= w_tcnt_inc;
          end
        end
        ST_DONE, ST_ERR: begin
          r_ptr   <= w_next_ptr;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign done     = r_done;
  assign err      = r_err;
  assign owner    = r_owner;
  assign busy     = r_busy;
  assign dp_start = r_start;
  assign dp_abort = r_abort;

endmodule

// File: tb/tb_det_cnt_scheduler.sv
// Bench for det_cnt_scheduler: directed scenarios plus randomized runs checked against a
// transaction-level round-robin / timing model with a simple datapath controller responder.
module tb_det_cnt_scheduler;

  localparam int NREQ    = 4;
  localparam int TO_W    = 10;
  localparam int TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic            dp_ready = 1'b1;
  logic [NREQ-1:0] gnt, done, err;
  logic [1:0]      owner;
  logic            busy, dp_start, dp_abort;

  always #5 clk = ~clk;

  det_cnt_scheduler #(
    .NREQ    (NREQ),
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .gnt      (gnt),
    .done     (done),
    .err      (err),
    .owner    (owner),
    .busy     (busy),
    .dp_start (dp_start),
    .dp_ready (dp_ready),
    .dp_abort (dp_abort)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int ctl_mode = 0;   // 0: normal run, 1: never acknowledges, 2: hangs busy
  int ctl_cnt  = 0;
  int run_len  = 4;
  int rise_cyc = -1;
  int ptr_m    = 0;   // reference round-robin pointer

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_winner(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // One clock: sample at the falling edge, check invariants, advance the controller model.
  task automatic tick();
    @(negedge clk);
    cyc++;
    chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
    chk("gnt_without_busy", 32'((gnt != 0) && !busy), 0);
    if (dp_abort) begin
      dp_ready = 1'b1;
      ctl_cnt  = 0;
    end else if (dp_start && ctl_mode != 1) begin
      dp_ready = 1'b0;
      ctl_cnt  = (ctl_mode == 0) ? run_len : 0;
    end else if (ctl_mode == 0 && !dp_ready && ctl_cnt > 0) begin
      ctl_cnt--;
      if (ctl_cnt == 0) begin
        dp_ready = 1'b1;
        rise_cyc = cyc;
      end
    end
  endtask

  // Expects arbitration on the coming edge with the current req; follows the run to its end.
  task automatic do_run(input int mode, input int rlen,
                        input logic [NREQ-1:0] pulse_m, input logic [NREQ-1:0] drop_m);
    int              w;
    int              s_cyc;
    int              got;
    logic [NREQ-1:0] w_oh;
    ctl_mode = mode;
    run_len  = rlen;
    rise_cyc = -1;
    w        = rr_winner(req, ptr_m);
    w_oh     = NREQ'(1) << w;
    tick();
    s_cyc = cyc;
    chk("gnt_at_grant", gnt, w_oh);
    chk("owner_at_grant", owner, w);
    chk("dp_start_pulse", dp_start, 1);
    chk("busy_at_grant", busy, 1);
    req = req | pulse_m;
    tick();
    chk("dp_start_width", dp_start, 0);
    chk("gnt_held", gnt, w_oh);
    req = req & ~pulse_m & ~drop_m;
    got = 0;
    for (int k = 0; k < 60 && got == 0; k++) begin
      tick();
      if (done != 0 || err != 0) got = 1;
    end
    chk("run_end_seen", got, 1);
    if (mode == 0) begin
      chk("done_vec", done, w_oh);
      chk("err_none", err, 0);
      chk("abort_none", dp_abort, 0);
      chk("done_latency", cyc, rise_cyc + 1);
    end else begin
      chk("err_vec", err, w_oh);
      chk("abort_pulse", dp_abort, 1);
      chk("done_none", done, 0);
      chk("err_latency", cyc, (mode == 1) ? (s_cyc + 1 + TIMEOUT) : (s_cyc + 2 + TIMEOUT));
    end
    chk("gnt_at_end", gnt, w_oh);
    tick();
    chk("gnt_drop", gnt, 0);
    chk("busy_drop", busy, 0);
    chk("done_1cyc", done, 0);
    chk("err_1cyc", err, 0);
    chk("abort_1cyc", dp_abort, 0);
    chk("owner_hold", owner, w);
    ptr_m = (w + 1) % NREQ;
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      tick();
      chk({tag, "_gnt"}, gnt, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
    end
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_owner", owner, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dp_start", dp_start, 0);
    chk("rst_dp_abort", dp_abort, 0);
    tick();
    tick();
    rst_n = 1'b1;
    idle_check(2, "post_rst_idle");

    // Single client
    req = 4'b0001;
    do_run(0, 10, '0, '0);
    req = '0;
    idle_check(2, "single_idle");

    // Contention, all clients held
    req = 4'b1111;
    for (int i = 0; i < 5; i++) do_run(0, $urandom_range(2, 12), '0, '0);
    req = '0;
    idle_check(1, "contend_idle");

    // Timeout in RUN, then the next client is served
    req = 4'b0110;
    do_run(2, 0, '0, '0);
    do_run(0, 5, '0, '0);
    // No acknowledge from the controller
    do_run(1, 0, '0, '0);
    req = '0;
    idle_check(2, "timeout_idle");

    // Short pulse on req[2] while busy is never granted; dropping req[0] mid-run is ignored
    req = 4'b0001;
    do_run(0, 8, 4'b0100, 4'b0001);
    idle_check(4, "withdraw_idle");

    // Hold off while the controller reports not ready
    dp_ready = 1'b0;
    ctl_mode = 0;
    ctl_cnt  = 0;
    req = 4'b0001;
    idle_check(5, "holdoff");
    dp_ready = 1'b1;
    do_run(0, 6, '0, '0);
    req = '0;

    // Reset in the middle of a run
    req = 4'b1000;
    ctl_mode = 0;
    run_len  = 12;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt", gnt, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_owner", owner, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    chk("midrst_abort", dp_abort, 0);
    chk("midrst_start", dp_start, 0);
    tick();
    rst_n    = 1'b1;
    req      = '0;
    dp_ready = 1'b1;
    ctl_cnt  = 0;
    ptr_m    = 0;
    idle_check(4, "after_rst");
    req = 4'b1111;
    do_run(0, 4, '0, '0);

    // Randomized runs
    for (int i = 0; i < 25; i++) begin
      req = NREQ'($urandom_range(1, 15));
      do_run(($urandom_range(0, 9) == 0) ? 2 : 0, $urandom_range(2, 12), '0, '0);
    end
    req = '0;
    idle_check(2, "final_idle");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
